// File: rtl/execute_mem_preg.sv
// rtl/execute_mem_preg.sv - Execute-to-Memory pipeline register with valid/ready handshake and one-entry skid buffer
// Optional feature macro: EXMEM_PERF_CNT_EN (adds stall_cnt / bubble_cnt performance counters)
module execute_mem_preg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      valid_e,
  output logic                      ready_e,
  input  logic [DATA_WIDTH-1:0]     ALUResultE,
  input  logic [DATA_WIDTH-1:0]     WriteDataE,
  input  logic [DATA_WIDTH-1:0]     PCPlus4E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      RegWriteE,
  input  logic                      MemWriteE,
  input  logic [1:0]                ResultSrcE,
  output logic                      valid_m,
  input  logic                      ready_m,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M,
  output logic [REG_ADDR_WIDTH-1:0] RdM,
  output logic                      RegWriteM,
  output logic                      MemWriteM,
  output logic [1:0]                ResultSrcM
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  // One held instruction: every field Execute hands to Memory/Writeback
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_write;
    logic [1:0]                result_src;
  } entry_t;

  // EMPTY: nothing held; FULL: main holds an entry; SKID: main and skid both hold entries
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q;
  logic   valid_q;
  logic   ready_q;
  entry_t in_entry;
  entry_t main_q;
  entry_t skid_q;
  logic   in_fire;
  logic   out_fire;

  assign in_entry.alu_result = ALUResultE;
  assign in_entry.write_data = WriteDataE;
  assign in_entry.pc_plus4   = PCPlus4E;
  assign in_entry.rd         = RdE;
  assign in_entry.reg_write  = RegWriteE;
  assign in_entry.mem_write  = MemWriteE;
  assign in_entry.result_src = ResultSrcE;

  // ready_e comes from a flop, so back-pressure from Memory never reaches Execute combinationally
  assign ready_e  = ready_q;
  assign valid_m  = valid_q;
  assign in_fire  = valid_e & ready_q;
  assign out_fire = valid_q & ready_m;

  // Occupancy FSM; valid/ready are registered alongside the state so they track it exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= FULL;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (in_fire && !out_fire) begin
            state_q <= SKID;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_q <= FULL;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Entry storage; a flush leaves the data untouched since the gated enables already hide it
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) main_q <= in_entry;
        end
        FULL: begin
          if (in_fire && out_fire) main_q <= in_entry;
          else if (in_fire)        skid_q <= in_entry;
        end
        SKID: begin
          // Skid always drains into main so the older entry leaves first
          if (out_fire) main_q <= skid_q;
        end
        default: ;
      endcase
    end
  end

  assign ALUResultM = main_q.alu_result;
  assign WriteDataM = main_q.write_data;
  assign PCPlus4M   = main_q.pc_plus4;
  assign RdM        = main_q.rd;
  assign ResultSrcM = main_q.result_src;
  // Write enables are qualified so a stale or flushed entry can never commit
  assign RegWriteM  = main_q.reg_write & valid_q;
  assign MemWriteM  = main_q.mem_write & valid_q;

`ifdef EXMEM_PERF_CNT_EN
  // Stall and bubble counters; only reset clears them, and they wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (valid_e && !ready_q) stall_cnt  <= stall_cnt + 32'd1;
      if (ready_m && !valid_q) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_mem_preg.sv
// tb/tb_execute_mem_preg.sv - directed self-checking bench for execute_mem_preg
module tb_execute_mem_preg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_e;
  logic        ready_e;
  logic [31:0] ALUResultE;
  logic [31:0] WriteDataE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        valid_m;
  logic        ready_m;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_mem_preg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_e(valid_e), .ready_e(ready_e),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .valid_m(valid_m), .ready_m(ready_m),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ready_m = 1'b0;
    valid_e = 1'b1; ALUResultE = 32'h55; WriteDataE = 32'h66; PCPlus4E = 32'h77;
    RdE = 5'd9; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'd3;
    step(); step();
    checks++;
    if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid_m got=%b exp=0", valid_m); end
    checks++;
    if (ready_e !== 1'b1) begin errors++; $display("FAIL reset_ready_e got=%b exp=1", ready_e); end
    checks++;
    if ({ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM, RegWriteM, MemWriteM} !== 105'd0) begin
      errors++;
      $display("FAIL reset_m_outputs alu=%h wd=%h pc=%h rd=%h rs=%h rw=%b mw=%b exp=all zero",
               ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM, RegWriteM, MemWriteM);
    end
    rst = 1'b0;
    ALUResultE = 32'h10;
    step();
    checks++;
    if (valid_m !== 1'b1) begin errors++; $display("FAIL first_valid_m got=%b exp=1", valid_m); end
    checks++;
    if (ALUResultM !== 32'h10) begin errors++; $display("FAIL first_alu got=%h exp=10", ALUResultM); end
    valid_e = 1'b0; ready_m = 1'b1;
    step();
    checks++;
    if (valid_m !== 1'b0) begin errors++; $display("FAIL first_drain_valid_m got=%b exp=0", valid_m); end
  endtask

  task automatic test_streaming();
    ready_m = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      valid_e = 1'b1;
      ALUResultE = 32'(i); WriteDataE = ~32'(i); PCPlus4E = 32'(4 * i);
      RdE = 5'(i); RegWriteE = i[0]; MemWriteE = ~i[0]; ResultSrcE = 2'(i);
      step();
      checks++;
      if (ready_e !== 1'b1) begin errors++; $display("FAIL stream_ready_e i=%0d got=%b exp=1", i, ready_e); end
      checks++;
      if (valid_m !== 1'b1 || ALUResultM !== 32'(i)) begin
        errors++; $display("FAIL stream_alu i=%0d got=%h v=%b exp=%h v=1", i, ALUResultM, valid_m, 32'(i));
      end
      checks++;
      if (WriteDataM !== ~32'(i) || PCPlus4M !== 32'(4 * i) || RdM !== 5'(i) ||
          RegWriteM !== i[0] || MemWriteM !== ~i[0] || ResultSrcM !== 2'(i)) begin
        errors++;
        $display("FAIL stream_fields i=%0d wd=%h pc=%h rd=%0d rw=%b mw=%b rs=%0d", i,
                 WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM);
      end
    end
    valid_e = 1'b0;
    step();
    checks++;
    if (valid_m !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", valid_m); end
  endtask

  task automatic test_skid();
    ready_m = 1'b0; valid_e = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b0;
    ALUResultE = 32'hA; step();
    ALUResultE = 32'hB; step();
    checks++;
    if (ready_e !== 1'b0 || valid_m !== 1'b1 || ALUResultM !== 32'hA) begin
      errors++; $display("FAIL skid_fill ready_e=%b valid_m=%b alu=%h exp 0 1 a", ready_e, valid_m, ALUResultM);
    end
    ALUResultE = 32'hC;
    step(); step();
    checks++;
    if (ready_e !== 1'b0 || ALUResultM !== 32'hA) begin
      errors++; $display("FAIL skid_hold ready_e=%b alu=%h exp 0 a", ready_e, ALUResultM);
    end
    ready_m = 1'b1;
    step();
    checks++;
    if (valid_m !== 1'b1 || ALUResultM !== 32'hB || ready_e !== 1'b1) begin
      errors++; $display("FAIL skid_drain_b valid_m=%b alu=%h ready_e=%b exp 1 b 1", valid_m, ALUResultM, ready_e);
    end
    step();
    checks++;
    if (valid_m !== 1'b1 || ALUResultM !== 32'hC) begin
      errors++; $display("FAIL skid_accept_c valid_m=%b alu=%h exp 1 c", valid_m, ALUResultM);
    end
    valid_e = 1'b0;
    step();
    checks++;
    if (valid_m !== 1'b0) begin errors++; $display("FAIL skid_empty got=%b exp=0", valid_m); end
  endtask

  task automatic test_flush();
    ready_m = 1'b0; valid_e = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
    ALUResultE = 32'hA1; step();
    ALUResultE = 32'hB1; step();
    flush = 1'b1; ALUResultE = 32'hD;
    step();
    flush = 1'b0; valid_e = 1'b0;
    checks++;
    if (valid_m !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ready_e !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill valid_m=%b rw=%b mw=%b ready_e=%b exp 0 0 0 1", valid_m, RegWriteM, MemWriteM, ready_e);
    end
    ready_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid_m !== 1'b0) begin errors++; $display("FAIL flush_no_d cyc=%0d valid_m=%b alu=%h exp valid 0", i, valid_m, ALUResultM); end
    end
    valid_e = 1'b1; ALUResultE = 32'hE;
    step();
    valid_e = 1'b0;
    checks++;
    if (valid_m !== 1'b1 || ALUResultM !== 32'hE || RegWriteM !== 1'b1) begin
      errors++; $display("FAIL flush_recover valid_m=%b alu=%h rw=%b exp 1 e 1", valid_m, ALUResultM, RegWriteM);
    end
    step();
  endtask

  task automatic test_gating();
    ready_m = 1'b1; valid_e = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || valid_m !== 1'b0) begin
        errors++; $display("FAIL gating cyc=%0d rw=%b mw=%b valid_m=%b exp 0 0 0", i, RegWriteM, MemWriteM, valid_m);
      end
    end
  endtask

`ifdef EXMEM_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1; ready_m = 1'b0; valid_e = 1'b0;
    step();
    rst = 1'b0; valid_e = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", stall_cnt); end
    checks++;
    if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL perf_bubble got=%0d exp=0", bubble_cnt); end
    valid_e = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_flush_keep got=%0d exp=3", stall_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_rst_clear got=%0d exp=0", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_gating();
`ifdef EXMEM_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
